simon_serial_ctrl: RTL and testbench

- Sequencing controller for the bit-serial SIMON 128/128 core.
- Accepts a start request and a serial bit stream (plaintext, then key), stepping the datapath and key expansion through load, run and done phases.
- Drives the shared `data_rdy[1:0]` and `bit_counter[5:0]` buses.
- Cross-checks the key-expansion round counter at end of encryption.

---
 rtl/simon_serial_ctrl.sv | 168 ++++++++++++++++
 tb/tb_simon_serial_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_serial_ctrl.sv
// Sequencing controller for the bit-serial SIMON 128/128 core.
// Steps the datapath through plaintext load, key load, the encryption run and done.
module simon_serial_ctrl #(
    parameter int WORD_BITS = 64,
    parameter int ROUNDS    = 68,
    parameter int LOAD_BITS = 128
) (
    input  logic       clk,
    input  logic       resetP,
    input  logic       start,
    input  logic       abort,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [6:0] round_counter,
    output logic [1:0] data_rdy,
    output logic [5:0] bit_counter,
    output logic       busy,
    output logic       ct_valid,
    input  logic       ct_ack,
    output logic       err
);

    localparam int RUN_CYCLES = ROUNDS * WORD_BITS;

    localparam logic [5:0]  BIT_LAST  = 6'(WORD_BITS - 1);
    localparam logic [6:0]  LOAD_LAST = 7'(LOAD_BITS - 1);
    localparam logic [12:0] RUN_LAST  = 13'(RUN_CYCLES - 1);
    localparam logic [6:0]  RC_FINAL  = 7'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PT,
        LOAD_KEY,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  load_cnt;
    logic [6:0]  load_cnt_next;
    logic [12:0] run_cnt;
    logic [12:0] run_cnt_next;
    logic [5:0]  bit_next;
    logic [5:0]  bit_inc;
    logic        err_next;
    logic        busy_next;
    logic        ct_valid_next;

    // din goes straight to the datapath shifters; the controller only gates it.
    logic unused_din;
    assign unused_din = din;

    assign bit_inc = (bit_counter == BIT_LAST) ? 6'd0 : bit_counter + 6'd1;

    always_ff @(posedge clk or negedge resetP) begin
        if (!resetP) begin
            state       <= IDLE;
            load_cnt    <= '0;
            run_cnt     <= '0;
            bit_counter <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            ct_valid    <= 1'b0;
        end else begin
            state       <= state_next;
            load_cnt    <= load_cnt_next;
            run_cnt     <= run_cnt_next;
            bit_counter <= bit_next;
            err         <= err_next;
            busy        <= busy_next;
            ct_valid    <= ct_valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        load_cnt_next = load_cnt;
        run_cnt_next  = run_cnt;
        bit_next      = bit_counter;
        err_next      = err;

        if (abort) begin
            state_next    = IDLE;
            load_cnt_next = '0;
            run_cnt_next  = '0;
            bit_next      = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next    = LOAD_PT;
                        err_next      = 1'b0;
                        load_cnt_next = '0;
                        run_cnt_next  = '0;
                        bit_next      = '0;
                    end
                end
                LOAD_PT, LOAD_KEY: begin
                    if (din_valid) begin
                        if (load_cnt == LOAD_LAST) begin
                            state_next    = (state == LOAD_PT) ? LOAD_KEY : RUN;
                            load_cnt_next = '0;
                            run_cnt_next  = '0;
                            bit_next      = '0;
                        end else begin
                            load_cnt_next = load_cnt + 7'd1;
                            bit_next      = bit_inc;
                        end
                    end
                end
                RUN: begin
                    bit_next = bit_inc;
                    // The key schedule must have reached its final round exactly as we finish.
                    if (run_cnt == RUN_LAST) begin
                        if (round_counter != RC_FINAL) begin
                            err_next = 1'b1;
                        end
                        state_next   = DONE;
                        run_cnt_next = '0;
                    end else begin
                        run_cnt_next = run_cnt + 13'd1;
                    end
                end
                DONE: begin
                    if (ct_ack) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    load_cnt_next = '0;
                    run_cnt_next  = '0;
                    bit_next      = '0;
                end
            endcase
        end

        busy_next     = (state_next == LOAD_PT) || (state_next == LOAD_KEY) ||
                        (state_next == RUN);
        ct_valid_next = (state_next == DONE);
    end

    // A stalled load cycle presents data_rdy=0 so the shifters freeze with the counters.
    always_comb begin
        data_rdy  = 2'd0;
        din_ready = 1'b0;
        case (state)
            LOAD_PT: begin
                din_ready = 1'b1;
                data_rdy  = din_valid ? 2'd1 : 2'd0;
            end
            LOAD_KEY: begin
                din_ready = 1'b1;
                data_rdy  = din_valid ? 2'd2 : 2'd0;
            end
            RUN: begin
                data_rdy = 2'd3;
            end
            default: begin
                data_rdy  = 2'd0;
                din_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_serial_ctrl.sv
// Bench for simon_serial_ctrl: randomized load stalls and data, checked every cycle
// against a phase/count reference model plus scenario checks.
module tb_simon_serial_ctrl;

    localparam int WORD_BITS  = 64;
    localparam int ROUNDS     = 68;
    localparam int LOAD_BITS  = 128;
    localparam int RUN_CYCLES = ROUNDS * WORD_BITS;
    localparam int MAX_CYCLES = 6000;

    logic       clk = 1'b0;
    logic       resetP = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       ct_ack = 1'b0;
    logic [6:0] round_counter = '0;
    logic       din_ready;
    logic [1:0] data_rdy;
    logic [5:0] bit_counter;
    logic       busy;
    logic       ct_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    int m_phase = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    int rc_idx = 0;
    bit force_bad = 1'b0;
    int seen_dr[4];

    simon_serial_ctrl #(
        .WORD_BITS(WORD_BITS),
        .ROUNDS(ROUNDS),
        .LOAD_BITS(LOAD_BITS)
    ) dut (
        .clk(clk),
        .resetP(resetP),
        .start(start),
        .abort(abort),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .round_counter(round_counter),
        .data_rdy(data_rdy),
        .bit_counter(bit_counter),
        .busy(busy),
        .ct_valid(ct_valid),
        .ct_ack(ct_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed,
                     expected, $time);
        end
    endtask

    // Phases: 0 idle, 1 plaintext load, 2 key load, 3 run, 4 done.
    always @(posedge clk or negedge resetP) begin
        if (!resetP) begin
            m_phase = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else if (abort) begin
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_err   = 1'b0;
                end
                1, 2: if (din_valid) begin
                    m_cnt++;
                    if (m_cnt == LOAD_BITS) begin
                        m_phase++;
                        m_cnt = 0;
                    end
                end
                3: begin
                    if (m_cnt == RUN_CYCLES - 1) begin
                        if (round_counter != 7'(ROUNDS - 1)) m_err = 1'b1;
                        m_phase = 4;
                        m_cnt   = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                4: if (ct_ack) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [31:0] expectedOutputs();
        logic [1:0] e_dr;
        logic [5:0] e_bc;
        e_dr = 2'd0;
        e_bc = 6'd0;
        if (m_phase == 1) e_dr = din_valid ? 2'd1 : 2'd0;
        if (m_phase == 2) e_dr = din_valid ? 2'd2 : 2'd0;
        if (m_phase == 3) e_dr = 2'd3;
        if (m_phase >= 1 && m_phase <= 3) e_bc = 6'(m_cnt % WORD_BITS);
        return {20'd0, e_dr, (m_phase == 1 || m_phase == 2), e_bc,
                (m_phase >= 1 && m_phase <= 3), (m_phase == 4), m_err};
    endfunction

    always @(negedge clk) begin
        checkOutput("cycle", {20'd0, data_rdy, din_ready, bit_counter, busy, ct_valid, err},
                    expectedOutputs());
        if (data_rdy != 2'd0) seen_dr[data_rdy]++;
    end

    // Key-expansion stand-in: advances one round per word of RUN, cleared whenever data_rdy=0.
    always @(negedge clk or negedge resetP) begin
        if (!resetP) begin
            rc_idx        = 0;
            round_counter = '0;
        end else if (data_rdy == 2'd3) begin
            round_counter = (force_bad && rc_idx == RUN_CYCLES - 1) ? 7'd66 :
                            7'(rc_idx / WORD_BITS);
            rc_idx++;
        end else begin
            rc_idx        = 0;
            round_counter = '0;
        end
    end

    task automatic applyStimulus(input bit s, input bit a, input bit dv, input bit ack);
        start     = s;
        abort     = a;
        din_valid = dv;
        din       = 1'($urandom_range(0, 1));
        ct_ack    = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic clearSeen();
        for (int i = 0; i < 4; i++) seen_dr[i] = 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_bitcnt"}, bit_counter, 0);
        checkOutput({tag, "_ctvalid"}, ct_valid, 0);
        checkOutput({tag, "_datardy"}, data_rdy, 0);
        checkOutput({tag, "_dinready"}, din_ready, 0);
    endtask

    // stall_mode: 0 none, 1 every third cycle, 2 random.
    task automatic runToDone(input int stall_mode, input bit ack_in_run, output int latency);
        bit dv;
        bit ack;
        clearSeen();
        applyStimulus(1, 0, 0, 0);
        latency = 1;
        while (!ct_valid && latency < MAX_CYCLES) begin
            case (stall_mode)
                0:       dv = 1'b1;
                1:       dv = (latency % 3) != 0;
                default: dv = $urandom_range(0, 3) != 0;
            endcase
            ack = ack_in_run && (data_rdy == 2'd3) && ($urandom_range(0, 7) == 0);
            applyStimulus(0, 0, dv, ack);
            latency++;
        end
        checkOutput("done_reached", ct_valid, 1);
        checkOutput("pt_bits", seen_dr[1], LOAD_BITS);
        checkOutput("key_bits", seen_dr[2], LOAD_BITS);
        checkOutput("run_len", seen_dr[3], RUN_CYCLES);
    endtask

    task automatic ackDone();
        applyStimulus(0, 0, 0, 1);
        checkOutput("ack_ctvalid", ct_valid, 0);
        checkOutput("ack_busy", busy, 0);
        applyStimulus(0, 0, 0, 0);
    endtask

    task automatic enterRun(input int run_cycles);
        applyStimulus(1, 0, 0, 0);
        repeat (2 * LOAD_BITS) applyStimulus(0, 0, 1, 0);
        repeat (run_cycles) applyStimulus(0, 0, 1'($urandom_range(0, 1)), 0);
    endtask

    initial begin
        int lat;

        repeat (3) applyStimulus(0, 0, 0, 0);
        checkIdleOutputs("reset");
        checkOutput("reset_err", err, 0);
        resetP = 1'b1;
        applyStimulus(0, 0, 0, 0);

        applyStimulus(1, 1, 1, 0);
        checkIdleOutputs("start_abort");
        applyStimulus(0, 0, 1, 0);
        checkOutput("start_abort_stay", busy, 0);

        runToDone(0, 1'b1, lat);
        checkOutput("latency", lat, 1 + 2 * LOAD_BITS + RUN_CYCLES);
        checkOutput("clean_err", err, 0);
        repeat (2) applyStimulus(1, 0, 0, 0);
        checkOutput("start_in_done_ct", ct_valid, 1);
        checkOutput("start_in_done_busy", busy, 0);
        ackDone();

        runToDone(1, 1'b0, lat);
        checkOutput("stall_latency_longer", lat > 1 + 2 * LOAD_BITS + RUN_CYCLES, 1);
        checkOutput("stall_err", err, 0);
        ackDone();

        force_bad = 1'b1;
        runToDone(2, 1'b1, lat);
        force_bad = 1'b0;
        checkOutput("bad_rc_err", err, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("err_after_ack", err, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("err_after_abort", err, 1);
        applyStimulus(1, 0, 1, 0);
        checkOutput("err_cleared_by_start", err, 0);
        applyStimulus(0, 1, 0, 0);
        checkIdleOutputs("abort_pt");

        applyStimulus(1, 0, 0, 0);
        repeat (LOAD_BITS + 70) applyStimulus(0, 0, 1, 0);
        checkOutput("key_bit70_pos", bit_counter, 70 % WORD_BITS);
        applyStimulus(0, 1, 1, 0);
        checkIdleOutputs("abort_key");
        repeat (4) applyStimulus(0, 0, 1, 1);
        checkOutput("abort_key_no_ct", ct_valid, 0);

        enterRun(2000);
        checkOutput("run2000_pos", bit_counter, 2000 % WORD_BITS);
        applyStimulus(0, 1, 0, 0);
        checkIdleOutputs("abort_run");
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("abort_run_no_ct", ct_valid, 0);

        enterRun(1000);
        resetP = 1'b0;
        #1;
        checkIdleOutputs("reset_run");
        checkOutput("reset_run_err", err, 0);
        applyStimulus(0, 0, 0, 0);
        resetP = 1'b1;
        applyStimulus(0, 0, 0, 0);
        runToDone(0, 1'b0, lat);
        checkOutput("latency_after_reset", lat, 1 + 2 * LOAD_BITS + RUN_CYCLES);
        ackDone();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
